// File: rtl/aw_burst_gen.sv
// ============================================================================
// Module   : aw_burst_gen
// Purpose  : Pops AW entries from a show-ahead FIFO and expands each into
//            per-beat write addresses (FIXED / INCR / WRAP) on a valid/ready port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module aw_burst_gen #(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_WIDTH  = 4,
  parameter int SIZE_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  empty,
  output logic                  pop,
  input  logic [ID_WIDTH-1:0]   front_AWID,
  input  logic [ADDR_WIDTH-1:0] front_AWADDR,
  input  logic [LEN_WIDTH-1:0]  front_AWLEN,
  input  logic [SIZE_WIDTH-1:0] front_AWSIZE,
  input  logic [1:0]            front_AWBURST,
  output logic                  beat_valid,
  input  logic                  beat_ready,
  output logic [ID_WIDTH-1:0]   beat_id,
  output logic [ADDR_WIDTH-1:0] beat_addr,
  output logic [SIZE_WIDTH-1:0] beat_size,
  output logic [LEN_WIDTH-1:0]  beat_idx,
  output logic                  beat_last,
  output logic                  busy,
  output logic                  burst_err
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  localparam logic [1:0] C_FIXED = 2'b00;
  localparam logic [1:0] C_INCR  = 2'b01;
  localparam logic [1:0] C_WRAP  = 2'b10;
  localparam logic [1:0] C_RSVD  = 2'b11;

  state_t                state_q, state_d;
  logic [ID_WIDTH-1:0]   id_q, id_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [SIZE_WIDTH-1:0] size_q, size_d;
  logic [LEN_WIDTH-1:0]  idx_q, idx_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [1:0]            burst_q, burst_d;
  logic                  err_q, err_d;

  logic                  in_burst;
  logic                  last;
  logic                  hs;
  logic                  load;
  logic                  wrap_len_ok;
  logic                  illegal;
  logic [1:0]            front_type;

  logic [ADDR_WIDTH-1:0] bytes;
  logic [ADDR_WIDTH-1:0] aligned;
  logic [ADDR_WIDTH-1:0] incr_addr;
  logic [ADDR_WIDTH-1:0] wrap_tot;
  logic [ADDR_WIDTH-1:0] wrap_low;
  logic [ADDR_WIDTH-1:0] next_addr;

  assign in_burst = (state_q == ST_BURST);
  assign last     = in_burst && (idx_q == len_q);
  assign hs       = in_burst && beat_ready;
  // Reset must not consume a FIFO entry, so pop is masked while rst is high.
  assign load     = !rst && !empty && (!in_burst || (hs && last));

  // Reserved bursts and non-power-of-two WRAP lengths degrade to INCR.
  always_comb begin
    wrap_len_ok = (32'(front_AWLEN) == 32'd1) || (32'(front_AWLEN) == 32'd3) ||
                  (32'(front_AWLEN) == 32'd7) || (32'(front_AWLEN) == 32'd15);
    illegal     = (front_AWBURST == C_RSVD) ||
                  ((front_AWBURST == C_WRAP) && !wrap_len_ok);
    front_type  = illegal ? C_INCR : front_AWBURST;
  end

  // The current beat address always lies inside the wrap window, so the
  // window base can be derived from it instead of storing the start address.
  always_comb begin
    bytes     = ADDR_WIDTH'(1) << size_q;
    aligned   = addr_q & ~(bytes - ADDR_WIDTH'(1));
    incr_addr = aligned + bytes;
    wrap_tot  = (ADDR_WIDTH'(len_q) + ADDR_WIDTH'(1)) << size_q;
    wrap_low  = addr_q & ~(wrap_tot - ADDR_WIDTH'(1));
    case (burst_q)
      C_FIXED: next_addr = addr_q;
      C_WRAP:  next_addr = (incr_addr == (wrap_low + wrap_tot)) ? wrap_low : incr_addr;
      default: next_addr = incr_addr;
    endcase
  end

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    addr_d  = addr_q;
    size_d  = size_q;
    idx_d   = idx_q;
    len_d   = len_q;
    burst_d = burst_q;
    err_d   = 1'b0;
    if (load) begin
      state_d = ST_BURST;
      id_d    = front_AWID;
      addr_d  = front_AWADDR;
      size_d  = front_AWSIZE;
      idx_d   = '0;
      len_d   = front_AWLEN;
      burst_d = front_type;
      err_d   = illegal;
    end else if (hs) begin
      if (last) begin
        state_d = ST_IDLE;
      end else begin
        idx_d  = idx_q + LEN_WIDTH'(1);
        addr_d = next_addr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      id_q    <= '0;
      addr_q  <= '0;
      size_q  <= '0;
      idx_q   <= '0;
      len_q   <= '0;
      burst_q <= C_FIXED;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      burst_q <= burst_d;
      err_q   <= err_d;
    end
  end

  assign pop        = load;
  assign beat_valid = in_burst;
  assign busy       = in_burst;
  assign beat_id    = id_q;
  assign beat_addr  = addr_q;
  assign beat_size  = size_q;
  assign beat_idx   = idx_q;
  assign beat_last  = last;
  assign burst_err  = err_q;

endmodule

`default_nettype wire

// File: tb/tb_aw_burst_gen.sv
// ============================================================================
// Module   : tb_aw_burst_gen
// Purpose  : Self-checking bench for aw_burst_gen with a FIFO model and a
//            burst-level address reference.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_aw_burst_gen;

  localparam int IDW = 4;
  localparam int AW  = 32;
  localparam int LW  = 4;
  localparam int SW  = 3;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           empty = 1'b1;
  logic           pop;
  logic [IDW-1:0] front_AWID = '0;
  logic [AW-1:0]  front_AWADDR = '0;
  logic [LW-1:0]  front_AWLEN = '0;
  logic [SW-1:0]  front_AWSIZE = '0;
  logic [1:0]     front_AWBURST = '0;
  logic           beat_valid;
  logic           beat_ready = 1'b0;
  logic [IDW-1:0] beat_id;
  logic [AW-1:0]  beat_addr;
  logic [SW-1:0]  beat_size;
  logic [LW-1:0]  beat_idx;
  logic           beat_last;
  logic           busy;
  logic           burst_err;

  aw_burst_gen #(.ID_WIDTH(IDW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .SIZE_WIDTH(SW)) dut (
    .clk(clk), .rst(rst), .empty(empty), .pop(pop),
    .front_AWID(front_AWID), .front_AWADDR(front_AWADDR), .front_AWLEN(front_AWLEN),
    .front_AWSIZE(front_AWSIZE), .front_AWBURST(front_AWBURST),
    .beat_valid(beat_valid), .beat_ready(beat_ready), .beat_id(beat_id),
    .beat_addr(beat_addr), .beat_size(beat_size), .beat_idx(beat_idx),
    .beat_last(beat_last), .busy(busy), .burst_err(burst_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [IDW-1:0] id;
    logic [AW-1:0]  addr;
    logic [LW-1:0]  len;
    logic [SW-1:0]  size;
    logic [1:0]     burst;
  } entry_t;

  typedef struct {
    logic [IDW-1:0] id;
    logic [AW-1:0]  addr;
    logic [SW-1:0]  size;
    logic [LW-1:0]  idx;
    logic           last;
  } beat_t;

  typedef struct {
    entry_t        e;
    int            nb;
    logic [AW-1:0] a [4];
    logic          err;
  } vec_t;

  entry_t        fifo_q[$];
  beat_t         exp_q[$];
  logic [AW-1:0] obs_addr[$];
  logic          err_exp = 1'b0;
  logic          err_seen;
  int            pops;
  int            cur_run;
  int            max_run;
  int            n_pass = 0;
  int            n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic logic is_illegal(entry_t e);
    return (e.burst == 2'b11) ||
           ((e.burst == 2'b10) && !(int'(e.len) inside {1, 3, 7, 15}));
  endfunction

  // Address of beat k straight from the burst rules, no iteration.
  function automatic logic [AW-1:0] model_addr(entry_t e, int k);
    logic [63:0] b, t, al, low, r;
    logic [1:0]  bt;
    bt  = is_illegal(e) ? 2'b01 : e.burst;
    b   = 64'd1 << e.size;
    al  = {32'd0, e.addr} & ~(b - 64'd1);
    if (k == 0 || bt == 2'b00) begin
      r = {32'd0, e.addr};
    end else if (bt == 2'b01) begin
      r = al + 64'(k) * b;
    end else begin
      t   = (64'(e.len) + 64'd1) * b;
      low = al & ~(t - 64'd1);
      r   = low + ((al - low + 64'(k) * b) % t);
    end
    return r[AW-1:0];
  endfunction

  function automatic void push_beats(entry_t e);
    beat_t b;
    for (int k = 0; k <= int'(e.len); k++) begin
      b.id   = e.id;
      b.addr = model_addr(e, k);
      b.size = e.size;
      b.idx  = LW'(k);
      b.last = (k == int'(e.len));
      exp_q.push_back(b);
    end
  endfunction

  // One clock: drive at negedge, check against the model, advance at posedge.
  task automatic step(input logic rdy, input logic r);
    logic   exp_pop, hs, pop_s;
    entry_t e;
    @(negedge clk);
    rst        = r;
    beat_ready = rdy;
    empty      = (fifo_q.size() == 0);
    if (fifo_q.size() != 0) begin
      front_AWID    = fifo_q[0].id;
      front_AWADDR  = fifo_q[0].addr;
      front_AWLEN   = fifo_q[0].len;
      front_AWSIZE  = fifo_q[0].size;
      front_AWBURST = fifo_q[0].burst;
    end
    #1;
    exp_pop = !r && (fifo_q.size() != 0) &&
              ((exp_q.size() == 0) || (rdy && exp_q.size() == 1));
    chk("pop", pop, exp_pop);
    chk("beat_valid", beat_valid, exp_q.size() != 0);
    chk("busy", busy, exp_q.size() != 0);
    chk("burst_err", burst_err, err_exp);
    if (exp_q.size() != 0) begin
      chk("beat_id", beat_id, exp_q[0].id);
      chk("beat_addr", beat_addr, exp_q[0].addr);
      chk("beat_size", beat_size, exp_q[0].size);
      chk("beat_idx", beat_idx, exp_q[0].idx);
      chk("beat_last", beat_last, exp_q[0].last);
    end
    hs    = beat_valid && rdy;
    pop_s = pop;
    if (hs) obs_addr.push_back(beat_addr);
    if (burst_err) err_seen = 1'b1;
    if (pop) pops++;
    if (beat_valid) begin
      cur_run++;
      if (cur_run > max_run) max_run = cur_run;
    end else begin
      cur_run = 0;
    end
    @(posedge clk);
    err_exp = 1'b0;
    if (r) begin
      exp_q.delete();
    end else begin
      if (hs && exp_q.size() != 0) void'(exp_q.pop_front());
      if (pop_s && fifo_q.size() != 0) begin
        e = fifo_q.pop_front();
        push_beats(e);
        err_exp = is_illegal(e);
      end
    end
  endtask

  task automatic run_until_idle(input logic rand_rdy, input int budget, output logic ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      step(rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1, 1'b0);
      if (fifo_q.size() == 0 && exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic clear_obs();
    obs_addr.delete();
    err_seen = 1'b0;
    pops     = 0;
    cur_run  = 0;
    max_run  = 0;
  endtask

  task automatic check_reset_values(input string tag);
    #1;
    chk({tag, "_valid"}, beat_valid, 0);
    chk({tag, "_busy"},  busy, 0);
    chk({tag, "_last"},  beat_last, 0);
    chk({tag, "_err"},   burst_err, 0);
    chk({tag, "_id"},    beat_id, 0);
    chk({tag, "_addr"},  beat_addr, 0);
    chk({tag, "_size"},  beat_size, 0);
    chk({tag, "_idx"},   beat_idx, 0);
  endtask

  function automatic entry_t mk(int id, logic [AW-1:0] a, int len, int size, int bt);
    entry_t e;
    e.id = IDW'(id); e.addr = a; e.len = LW'(len); e.size = SW'(size); e.burst = 2'(bt);
    return e;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t   vec [8];
    logic   ok;
    entry_t e;
    logic   rdy_pat [4];

    vec[0].e = mk(1, 32'h1000, 3, 2, 1); vec[0].nb = 4; vec[0].err = 0;
    vec[0].a = '{32'h1000, 32'h1004, 32'h1008, 32'h100C};
    vec[1].e = mk(2, 32'h1008, 3, 2, 2); vec[1].nb = 4; vec[1].err = 0;
    vec[1].a = '{32'h1008, 32'h100C, 32'h1000, 32'h1004};
    vec[2].e = mk(3, 32'h1001, 2, 2, 1); vec[2].nb = 3; vec[2].err = 0;
    vec[2].a = '{32'h1001, 32'h1004, 32'h1008, 32'h0};
    vec[3].e = mk(4, 32'h2000, 2, 2, 0); vec[3].nb = 3; vec[3].err = 0;
    vec[3].a = '{32'h2000, 32'h2000, 32'h2000, 32'h0};
    vec[4].e = mk(5, 32'h3000, 1, 3, 3); vec[4].nb = 2; vec[4].err = 1;
    vec[4].a = '{32'h3000, 32'h3008, 32'h0, 32'h0};
    vec[5].e = mk(6, 32'h4004, 2, 2, 2); vec[5].nb = 3; vec[5].err = 1;
    vec[5].a = '{32'h4004, 32'h4008, 32'h400C, 32'h0};
    vec[6].e = mk(7, 32'hFFFF_FFFC, 1, 2, 1); vec[6].nb = 2; vec[6].err = 0;
    vec[6].a = '{32'hFFFF_FFFC, 32'h0, 32'h0, 32'h0};
    vec[7].e = mk(8, 32'h5002, 1, 1, 2); vec[7].nb = 2; vec[7].err = 0;
    vec[7].a = '{32'h5002, 32'h5000, 32'h0, 32'h0};

    clear_obs();
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    check_reset_values("reset");

    // Directed table, ready held high.
    for (int v = 0; v < 8; v++) begin
      clear_obs();
      fifo_q.push_back(vec[v].e);
      run_until_idle(1'b0, 40, ok);
      chk($sformatf("vec%0d_done", v), ok, 1);
      chk($sformatf("vec%0d_nbeats", v), obs_addr.size(), vec[v].nb);
      for (int k = 0; k < vec[v].nb; k++)
        chk($sformatf("vec%0d_addr%0d", v, k),
            (k < obs_addr.size()) ? obs_addr[k] : 'x, vec[v].a[k]);
      chk($sformatf("vec%0d_err", v), err_seen, vec[v].err);
      chk($sformatf("vec%0d_pops", v), pops, 1);
    end

    // Backpressure: ready 1,0,0,1 during an INCR burst.
    clear_obs();
    fifo_q.push_back(mk(9, 32'h6000, 3, 2, 1));
    rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    step(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(rdy_pat[i], 1'b0);
    run_until_idle(1'b0, 20, ok);
    chk("bp_done", ok, 1);
    chk("bp_nbeats", obs_addr.size(), 4);
    chk("bp_addr3", (obs_addr.size() == 4) ? obs_addr[3] : 'x, 32'h600C);
    chk("bp_pops", pops, 1);

    // Back-to-back: LEN=0 then LEN=1, no bubble between bursts.
    clear_obs();
    fifo_q.push_back(mk(10, 32'h7000, 0, 2, 1));
    fifo_q.push_back(mk(11, 32'h7100, 1, 2, 1));
    run_until_idle(1'b0, 20, ok);
    step(1'b1, 1'b0);
    chk("b2b_done", ok, 1);
    chk("b2b_valid_run", max_run, 3);
    chk("b2b_pops", pops, 2);
    chk("b2b_addr1", (obs_addr.size() == 3) ? obs_addr[1] : 'x, 32'h7100);

    // Reset mid-burst, then the next queued entry loads from idx 0.
    clear_obs();
    fifo_q.push_back(mk(12, 32'h8000, 3, 2, 1));
    fifo_q.push_back(mk(13, 32'h9000, 1, 0, 1));
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    check_reset_values("midrst");
    step(1'b0, 1'b1);
    chk("midrst_fifo_kept", fifo_q.size(), 1);
    obs_addr.delete();
    run_until_idle(1'b0, 20, ok);
    chk("midrst_done", ok, 1);
    chk("midrst_nbeats", obs_addr.size(), 2);
    chk("midrst_addr1", (obs_addr.size() == 2) ? obs_addr[1] : 'x, 32'h9001);

    // Randomized traffic against the reference model.
    for (int it = 0; it < 80; it++) begin
      int n;
      n = int'($urandom_range(0, 2));
      for (int j = 0; j < n; j++) begin
        e = mk(int'($urandom_range(0, 15)), $urandom, int'($urandom_range(0, 15)),
               int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        fifo_q.push_back(e);
      end
      repeat ($urandom_range(1, 12)) step(1'($urandom_range(0, 1)), 1'b0);
    end
    run_until_idle(1'b1, 4000, ok);
    chk("rand_drain", ok, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/aw_burst_gen.md
Name: aw_burst_gen

Overview:
Single-clock read-side consumer of the write-address FIFO. It pops one AW entry (ID, ADDR, LEN, SIZE, BURST) from a show-ahead FIFO front and expands it into a sequence of per-beat write addresses for FIXED, INCR and WRAP bursts. Each beat is presented on a valid/ready beat interface to the slave-side write datapath. It sits between the AW FIFO output and the slave write port.

Parameters:
ID_WIDTH, 4, AWID width
ADDR_WIDTH, 32, address width
LEN_WIDTH, 4, AWLEN width (beats = AWLEN+1, max 2^LEN_WIDTH)
SIZE_WIDTH, 3, AWSIZE width (bytes per beat = 1<<AWSIZE)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
empty  in  1  FIFO empty; when 0, the front_* inputs are valid (show-ahead)
pop  out  1  one-cycle pulse; FIFO advances its front on the next edge
front_AWID  in  ID_WIDTH  FIFO front ID
front_AWADDR  in  ADDR_WIDTH  FIFO front start address
front_AWLEN  in  LEN_WIDTH  FIFO front beats-1
front_AWSIZE  in  SIZE_WIDTH  FIFO front log2 bytes per beat
front_AWBURST  in  2  FIFO front burst type: 00 FIXED, 01 INCR, 10 WRAP, 11 reserved
beat_valid  out  1  beat address valid
beat_ready  in  1  consumer accepts beat
beat_id  out  ID_WIDTH  ID of the current burst
beat_addr  out  ADDR_WIDTH  address of the current beat
beat_size  out  SIZE_WIDTH  SIZE of the current burst
beat_idx  out  LEN_WIDTH  beat index within the burst, 0-based
beat_last  out  1  current beat is the final beat
busy  out  1  a burst is in progress (state BURST)
burst_err  out  1  one-cycle pulse when an illegal burst is loaded

Behaviour:
- Interface decision: one clock, clk; reset rst is synchronous and active-high.
- Reset values: state=IDLE. pop, beat_valid, beat_last, busy, burst_err = 0. beat_id, beat_addr, beat_size, beat_idx = 0.
- FSM with two states, IDLE and BURST.
- IDLE, empty=0: assert pop combinationally in the same cycle. Capture the front_* fields, set beat_idx=0, go to BURST on the next edge.
- IDLE, empty=1: hold; pop=0.
- Load-to-first-beat latency is 1 cycle: beat_valid rises the cycle after pop.
- BURST: beat_valid=1 and busy=1. beat_* outputs are registered and stay stable while beat_valid=1 and beat_ready=0.
- beat_last=1 exactly when beat_idx == captured LEN.
- Handshake (beat_valid and beat_ready) with beat_last=0: beat_idx+1, beat_addr advances to the next address.
- Handshake with beat_last=1 and empty=0: pop=1 in that cycle and the next burst loads directly. There are no bubble cycles; beat_valid stays 1.
- Handshake with beat_last=1 and empty=1: go to IDLE; beat_valid=0 next cycle.
- pop is never asserted while empty=1, and never in BURST except on the final-beat handshake.
- Address arithmetic: B = 1<<SIZE; aligned(a) = a with the low SIZE bits cleared.
  - FIXED: every beat uses the start address.
  - INCR: next = aligned(cur) + B, modulo 2^ADDR_WIDTH, so the first beat of an unaligned start keeps its unaligned address. Wrap-around at the top of the address space is silent.
  - WRAP: total T = (LEN+1)*B; low = start & ~(T-1); next = aligned(cur) + B; if next == low + T then next = low.
- Illegal bursts:
  - BURST=11: treated as INCR; burst_err pulses in the cycle after the load.
  - WRAP with LEN not in {1,3,7,15}: treated as INCR; burst_err pulses.
  - burst_err has no effect on any other behaviour.
- Reset mid-burst: the in-flight burst is abandoned and outputs return to reset values next cycle. FIFO contents are untouched; the next entry is popped after reset deasserts.

Test Plan:
1. INCR: ADDR=0x1000, LEN=3, SIZE=2, beat_ready=1 -> beat_addr 0x1000, 0x1004, 0x1008, 0x100C; beat_last only on idx 3; single pop; back to IDLE.
2. WRAP: ADDR=0x1008, LEN=3, SIZE=2 -> 0x1008, 0x100C, 0x1000, 0x1004; last on the 4th beat; burst_err=0.
3. Unaligned INCR 0x1001, LEN=2, SIZE=2 -> 0x1001, 0x1004, 0x1008. FIXED 0x2000, LEN=2 -> 0x2000 x3.
4. Backpressure: beat_ready toggles 1,0,0,1 during an INCR burst -> beat_addr/beat_idx held across stall cycles; no pop in BURST except on the final handshake.
5. Back-to-back: two entries queued (LEN=0 and LEN=1) -> beat_valid continuous for 3 cycles; pop on cycle 0 and on the last-beat handshake of burst 1; IDs switch with no bubble.
6. Error/reset: BURST=11 -> burst_err one-cycle pulse, INCR addresses. WRAP LEN=2 -> burst_err pulse. rst=1 mid-burst -> beat_valid=0 next cycle; after release, the next FIFO entry loads with idx=0.
